// File: rtl/led_display_frame_reader_if.sv
// Frame RAM read port and PHY pixel stream of the LED frame reader.
// master: the frame reader. slave: the frame RAM and the PHY shifter.
interface led_display_frame_reader_if #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int PIXEL_BITS     = 3
);
  localparam int HALF_ROWS = NUM_ROW_PIXELS / 2;
  localparam int ADDR_W    = $clog2(HALF_ROWS * NUM_COL_PIXELS);
  localparam int ROW_W     = $clog2(HALF_ROWS);
  localparam int WORD_W    = 2 * PIXEL_BITS;

  logic              ram_rd_en_out;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [WORD_W-1:0] ram_data_in;

  logic [WORD_W-1:0] pix_data_out;
  logic              pix_valid_out;
  logic              pix_ready_in;
  logic [ROW_W-1:0]  pix_row_out;
  logic              pix_last_col_out;
  logic              pix_last_row_out;

  modport master (
    output ram_rd_en_out, ram_addr_out,
    input  ram_data_in,
    output pix_data_out, pix_valid_out, pix_row_out, pix_last_col_out, pix_last_row_out,
    input  pix_ready_in
  );

  modport slave (
    input  ram_rd_en_out, ram_addr_out,
    output ram_data_in,
    input  pix_data_out, pix_valid_out, pix_row_out, pix_last_col_out, pix_last_row_out,
    output pix_ready_in
  );
endinterface

// File: rtl/led_display_frame_reader.sv
// Streams one frame of top/bottom pixel-pair words from the frame RAM to the
// LED PHY. Reads are credit-paced against a 2-entry output buffer so the
// 1-cycle RAM latency never overflows it under PHY back-pressure.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for frame_start_in, no reads
// S_READ  | issuing RAM reads column-first while credits allow
// S_DRAIN | all reads issued, waiting for the final beat to be accepted
module led_display_frame_reader #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int PIXEL_BITS     = 3
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic frame_start_in,
  output logic busy_out,
  output logic frame_done_out,
  led_display_frame_reader_if.master bus
);
  localparam int HALF_ROWS = NUM_ROW_PIXELS / 2;
  localparam int ADDR_W    = $clog2(HALF_ROWS * NUM_COL_PIXELS);
  localparam int ROW_W     = $clog2(HALF_ROWS);
  localparam int COL_W     = $clog2(NUM_COL_PIXELS);
  localparam int WORD_W    = 2 * PIXEL_BITS;
  // buffer entry: {row, last_row, last_col, data}
  localparam int ENT_W     = ROW_W + 2 + WORD_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ROW_W-1:0]  r_rd_row;
  logic [COL_W-1:0]  r_rd_col;
  logic              w_rd_last_col;
  logic              w_rd_last_row;
  logic              w_rd_en;
  logic              w_load;
  logic              w_done;
  logic              w_credit;

  logic              r_p_vld;
  logic [ROW_W-1:0]  r_p_row;
  logic              r_p_lc;
  logic              r_p_lr;

  logic [ENT_W-1:0]  r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic [ENT_W-1:0]  w_head;
  logic              w_push;
  logic              w_pop;

  logic              r_frame_done;

  assign w_rd_last_col = (r_rd_col == COL_W'(NUM_COL_PIXELS - 1));
  assign w_rd_last_row = (r_rd_row == ROW_W'(HALF_ROWS - 1));

  assign w_head = r_mem[r_rptr];
  assign w_push = r_p_vld;
  assign w_pop  = (r_count != 2'd0) && bus.pix_ready_in;

  // A read may issue when buffered + in-flight beats, less the one leaving
  // this cycle, stay below 2; counting the pop keeps full throughput.
  assign w_credit = ({1'b0, r_count} + {2'b00, r_p_vld}) < (3'd2 + {2'b00, w_pop});

  // State register.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start_in) begin
          w_load      = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (w_credit) begin
          w_rd_en = 1'b1;
          if (w_rd_last_col && w_rd_last_row) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head[WORD_W] && w_head[WORD_W+1]) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read address counters, column first; they wrap back to 0 after the last word.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_rd_row <= '0;
      r_rd_col <= '0;
    end else if (w_load) begin
      r_rd_row <= '0;
      r_rd_col <= '0;
    end else if (w_rd_en) begin
      if (w_rd_last_col) begin
        r_rd_col <= '0;
        r_rd_row <= w_rd_last_row ? '0 : r_rd_row + ROW_W'(1);
      end else begin
        r_rd_col <= r_rd_col + COL_W'(1);
      end
    end
  end

  // Sideband travels alongside the RAM's 1-cycle read latency.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_p_vld <= 1'b0;
      r_p_row <= '0;
      r_p_lc  <= 1'b0;
      r_p_lr  <= 1'b0;
    end else begin
      r_p_vld <= w_rd_en;
      if (w_rd_en) begin
        r_p_row <= r_rd_row;
        r_p_lc  <= w_rd_last_col;
        r_p_lr  <= w_rd_last_row;
      end
    end
  end

  // 2-entry output buffer; the head only moves on a handshake, so it holds while stalled.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {r_p_row, r_p_lr, r_p_lc, bus.ram_data_in};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // End-of-frame pulse, one cycle after the final handshake.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
    end
  end

  assign bus.ram_rd_en_out = w_rd_en;
  assign bus.ram_addr_out  = ADDR_W'(r_rd_row) * ADDR_W'(NUM_COL_PIXELS) + ADDR_W'(r_rd_col);

  assign bus.pix_valid_out    = (r_count != 2'd0);
  assign bus.pix_data_out     = w_head[WORD_W-1:0];
  assign bus.pix_last_col_out = w_head[WORD_W];
  assign bus.pix_last_row_out = w_head[WORD_W+1];
  assign bus.pix_row_out      = w_head[ENT_W-1 -: ROW_W];

  assign busy_out       = (r_state != S_IDLE);
  assign frame_done_out = r_frame_done;
endmodule

// File: tb/tb_led_display_frame_reader.sv
// Scoreboard bench for led_display_frame_reader: stimulus pushes the expected
// beat sequence of each accepted frame; a negedge monitor pops on every
// handshake and also watches stall stability and read credit pacing.
module tb_led_display_frame_reader;
  localparam int NR = 32;
  localparam int NC = 64;
  localparam int PB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  logic [11:0] exp_q[$];

  led_display_frame_reader_if #(.NUM_ROW_PIXELS(NR), .NUM_COL_PIXELS(NC), .PIXEL_BITS(PB)) bus ();

  led_display_frame_reader #(.NUM_ROW_PIXELS(NR), .NUM_COL_PIXELS(NC), .PIXEL_BITS(PB)) dut (
    .clk_in        (clk),
    .n_reset_in    (rst_n),
    .frame_start_in(start),
    .busy_out      (busy),
    .frame_done_out(done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Frame RAM preloaded with word = addr[5:0], 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_rd_en_out) bus.ram_data_in <= bus.ram_addr_out[5:0];
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Beat i: data=i[5:0], row=i/64, last_col every 64th, last_row for beats 960..1023.
  function automatic logic [11:0] beat_of(input int i);
    return {i[9:6], (i >= 960), (i[5:0] == 6'd63), i[5:0]};
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 1024; i++) exp_q.push_back(beat_of(i));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},    int'(bus.ram_rd_en_out), 0);
    check({tag, "_addr"},     int'(bus.ram_addr_out), 0);
    check({tag, "_data"},     int'(bus.pix_data_out), 0);
    check({tag, "_valid"},    int'(bus.pix_valid_out), 0);
    check({tag, "_row"},      int'(bus.pix_row_out), 0);
    check({tag, "_last_col"}, int'(bus.pix_last_col_out), 0);
    check({tag, "_last_row"}, int'(bus.pix_last_row_out), 0);
    check({tag, "_busy"},     int'(busy), 0);
    check({tag, "_done"},     int'(done), 0);
  endtask

  // Monitor: scoreboard pop, stall hold, and read credit limit.
  int          issued;
  int          accepted;
  logic        prev_stall;
  logic [11:0] prev_beat;
  logic        mon_hs;
  logic [11:0] act_beat;
  logic [11:0] exp_beat;

  assign act_beat = {bus.pix_row_out, bus.pix_last_row_out, bus.pix_last_col_out, bus.pix_data_out};

  always @(negedge clk) begin
    if (!rst_n) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      mon_hs = bus.pix_valid_out && bus.pix_ready_in;
      if (prev_stall) begin
        check("stall_valid_kept", int'(bus.pix_valid_out), 1);
        check("stall_beat_held", int'(act_beat), int'(prev_beat));
      end
      if (mon_hs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", act_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", int'(act_beat), int'(exp_beat));
        end
      end
      if (bus.ram_rd_en_out) begin
        check("outstanding_le2", (issued + 1 - accepted - int'(mon_hs) <= 2) ? 1 : 0, 1);
      end
      issued     = issued + int'(bus.ram_rd_en_out);
      accepted   = accepted + int'(mon_hs);
      prev_stall = bus.pix_valid_out && !bus.pix_ready_in;
      prev_beat  = act_beat;
    end
  end

  // Runs one frame whose start is asserted in the current cycle (k=0).
  // mode: 0 ready=1, 1 random ready, 2 ready low for k<=20, 3 stall then reset at k=305.
  task automatic run_frame(input int mode, input int ign_a, input int ign_b, input bit chain,
                           output int first_v, output int done_k, output int n_done,
                           output int rd_early);
    int k = 0;
    bit fin = 1'b0;
    first_v = -1;
    done_k = -1;
    n_done = 0;
    rd_early = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      k++;
      start = (k == ign_a) || (k == ign_b);
      case (mode)
        0:       bus.pix_ready_in = 1'b1;
        1:       bus.pix_ready_in = 1'($urandom_range(0, 1));
        2:       bus.pix_ready_in = (k > 20);
        3:       bus.pix_ready_in = (k < 300);
        default: bus.pix_ready_in = 1'b1;
      endcase
      @(negedge clk);
      if (k == 1) begin
        check("start_busy", int'(busy), 1);
        check("start_rd_en", int'(bus.ram_rd_en_out), 1);
        check("start_addr", int'(bus.ram_addr_out), 0);
      end
      if (bus.pix_valid_out && first_v < 0) first_v = k;
      if (k <= 20 && bus.ram_rd_en_out) rd_early++;
      if (mode == 2 && k >= 3 && k <= 20) begin
        check("stall_valid", int'(bus.pix_valid_out), 1);
        check("stall_word0", int'(bus.pix_data_out), 0);
      end
      if (mode == 2 && k >= 21 && k <= 23) begin
        check("release_consecutive", int'(bus.pix_valid_out && bus.pix_ready_in), 1);
      end
      if (mode == 3 && k == 305) begin
        check("full_before_rst", int'(bus.pix_valid_out), 1);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        fin = 1'b1;
      end else if (done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          check("done_busy_low", int'(busy), 0);
          check("done_queue_empty", exp_q.size(), 0);
          if (chain) begin
            start = 1'b1;
            push_frame();
            fin = 1'b1;
          end
        end
      end
      if (done_k > 0 && k >= done_k + 2) fin = 1'b1;
      if (!fin && k >= 6000) begin
        total++;
        bad++;
        $display("FAIL frame_timeout: got no frame_done after %0d cycles expected one", k);
        fin = 1'b1;
      end
    end
  endtask

  int fv, dk, nd, re;

  initial begin
    bus.pix_ready_in = 1'b0;

    // Reset, with a start pulse while reset is held.
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_zero("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_zero("idle_after_rst");
    end

    // Frame A: ready=1, starts at beat ~500 and on the last handshake ignored,
    // restart on the frame_done cycle chains into frame B.
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    run_frame(0, 500, 1026, 1'b1, fv, dk, nd, re);
    check("a_first_valid", fv, 3);
    check("a_done_cycle", dk, 1027);
    check("a_done_count", nd, 1);

    // Frame B: random ready, chains into the stall frame.
    run_frame(1, -1, -1, 1'b1, fv, dk, nd, re);
    check("b_done_count", nd, 1);

    // Frame C: ready low for 20 cycles after start.
    run_frame(2, -1, -1, 1'b0, fv, dk, nd, re);
    check("c_reads_while_stalled", re, 2);
    check("c_first_valid", fv, 3);
    check("c_done_cycle", dk, 1045);
    check("c_done_count", nd, 1);

    // Frame D: reset mid-frame with buffer full.
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    run_frame(3, -1, -1, 1'b0, fv, dk, nd, re);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check_zero("held_rst");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame E: restart from addr 0 / row 0 after reset.
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    run_frame(0, -1, -1, 1'b0, fv, dk, nd, re);
    check("e_first_valid", fv, 3);
    check("e_done_cycle", dk, 1027);
    check("e_done_count", nd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
